// File: rtl/div_seq_if.sv
// Handshake and data bundle for the sequential divider.
// master drives start/operands; slave returns results and status.
interface div_seq_if #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8,
    parameter int CNT_W      = 4
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic [CNT_W-1:0]      count;
    logic [3:0]            state_out;
    logic                  done;
    logic                  busy;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, count, state_out,
        input  done, busy, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, count, state_out,
        output done, busy, div_by_zero
    );
endinterface

// File: rtl/div_seq_control.sv
// Sequential restoring divider, one quotient bit per clock, with FSM,
// iteration counter and quotient/remainder datapath.
// Ports: clk, reset_a (sync, active-high), bus (div_seq_if.slave):
//   start/dividend/divisor in; quotient/remainder/count/state_out/
//   done/busy/div_by_zero out.
// Option macro SIGNED_DIV_EN: two's complement truncating division.
module div_seq_control #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8,
    parameter int CNT_W      = 4
) (
    input logic       clk,
    input logic       reset_a,
    div_seq_if.slave  bus
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_LOAD = 4'd1;
    localparam logic [3:0] S_CALC = 4'd2;
    localparam logic [3:0] S_DONE = 4'd8;
    localparam logic [3:0] S_ERR  = 4'd9;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

    logic [3:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVISOR_W-1:0]  acc_q, acc_d;
    logic [DIVIDEND_W-1:0] sh_q, sh_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W:0]    rs;
    logic [DIVISOR_W-1:0]  diff;
    logic                  ge;
    logic [DIVIDEND_W-1:0] q_nx;
    logic [DIVISOR_W-1:0]  r_nx;
    logic [DIVIDEND_W-1:0] a_ld;
    logic [DIVISOR_W-1:0]  b_ld;
    logic [DIVIDEND_W-1:0] q_fin;
    logic [DIVISOR_W-1:0]  r_fin;

    // Low bits suffice for the subtraction: when rs >= divisor the
    // difference is below the divisor and fits DIVISOR_W bits.
    assign rs   = {acc_q, sh_q[DIVIDEND_W-1]};
    assign ge   = rs >= {1'b0, dvs_q};
    assign diff = rs[DIVISOR_W-1:0] - dvs_q;
    assign q_nx = {sh_q[DIVIDEND_W-2:0], ge};
    assign r_nx = ge ? diff : rs[DIVISOR_W-1:0];

`ifdef SIGNED_DIV_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic a_neg, b_neg;

    assign a_neg = bus.dividend[DIVIDEND_W-1];
    assign b_neg = bus.divisor[DIVISOR_W-1];
    // Magnitudes; the most negative value maps onto itself, which is
    // its correct unsigned magnitude.
    assign a_ld  = a_neg ? -bus.dividend : bus.dividend;
    assign b_ld  = b_neg ? -bus.divisor : bus.divisor;
    assign q_fin = qneg_q ? -q_nx : q_nx;
    assign r_fin = rneg_q ? -r_nx : r_nx;
`else
    assign a_ld  = bus.dividend;
    assign b_ld  = bus.divisor;
    assign q_fin = q_nx;
    assign r_fin = r_nx;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_LOAD;
            end
            S_LOAD: begin
                cnt_d = '0;
                acc_d = '0;
                sh_d  = a_ld;
                dvs_d = b_ld;
`ifdef SIGNED_DIV_EN
                qneg_d = a_neg ^ b_neg;
                rneg_d = a_neg;
`endif
                if (bus.start) begin
                    state_d = S_ERR;
                end else if (bus.divisor == '0) begin
                    state_d = S_ERR;
                    dbz_d   = 1'b1;
                    quo_d   = '1;
                    rem_d   = bus.dividend[DIVISOR_W-1:0];
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (bus.start) begin
                    // Abort: expose the partial working values.
                    state_d = S_ERR;
                    quo_d   = sh_q;
                    rem_d   = acc_q;
                end else begin
                    acc_d = r_nx;
                    sh_d  = q_nx;
                    if (cnt_q == LAST) begin
                        state_d = S_DONE;
                        quo_d   = q_fin;
                        rem_d   = r_fin;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = bus.start ? S_LOAD : S_IDLE;
            end
            S_ERR: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_a) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.count       = cnt_q;
    assign bus.state_out   = state_q;
    assign bus.done        = (state_q == S_DONE);
    assign bus.busy        = (state_q == S_LOAD) || (state_q == S_CALC);
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_seq_control.sv
// Self-checking bench for div_seq_control.
// Scoreboard queue of expected quotient/remainder, popped on done.
module tb_div_seq_control;
    logic clk = 1'b0;
    logic reset_a;

    always #5 clk = ~clk;

    div_seq_if #(.DIVIDEND_W(16), .DIVISOR_W(8), .CNT_W(4)) bus ();

    div_seq_control #(.DIVIDEND_W(16), .DIVISOR_W(8), .CNT_W(4)) dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus)
    );

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
`ifdef SIGNED_DIV_EN
        int sa, sd, qi, ri;
        sa = int'($signed(a));
        sd = int'($signed(b));
        qi = sa / sd;
        ri = sa % sd;
        e.q = qi[15:0];
        e.r = ri[7:0];
`else
        e.q = a / {8'd0, b};
        e.r = 8'(a % {8'd0, b});
`endif
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start, pass the load edge, then scramble the operands.
    task automatic start_op(input logic [15:0] a, input logic [7:0] b,
                            input bit push);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        tick();
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
        if (push) sbq.push_back(model(a, b));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic pop_exp(output exp_t e);
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL sb_empty got=0 required=1");
            e = '0;
        end else begin
            e = sbq.pop_front();
        end
    endtask

    task automatic test_reset;
        reset_a      = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = 16'd0;
        bus.divisor  = 8'd0;
        repeat (3) tick();
        checks++;
        if ({bus.state_out, bus.count, bus.done, bus.busy,
             bus.div_by_zero} !== 11'd0) begin
            failures++;
            $display("FAIL rst_ctl got=%h required=0",
                     {bus.state_out, bus.count, bus.done, bus.busy,
                      bus.div_by_zero});
        end
        checks++;
        if ({bus.quotient, bus.remainder} !== 24'd0) begin
            failures++;
            $display("FAIL rst_res got=%h required=0",
                     {bus.quotient, bus.remainder});
        end
        reset_a = 1'b0;
        tick();
    endtask

    task automatic test_latency;
        exp_t e;
        int   n;
        start_op(16'd1000, 8'd7, 1'b1);
        checks++;
        if (bus.state_out !== 4'd2 || bus.busy !== 1'b1 ||
            bus.count !== 4'd0) begin
            failures++;
            $display("FAIL calc_entry got=%0d/%0b/%0d required=2/1/0",
                     bus.state_out, bus.busy, bus.count);
        end
        wait_done(n);
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL latency got=%0d required=16", n);
        end
        pop_exp(e);
`ifndef SIGNED_DIV_EN
        checks++;
        if (bus.quotient !== 16'd142 || bus.remainder !== 8'd6) begin
            failures++;
            $display("FAIL q_1000_7 got=%0d/%0d required=142/6",
                     bus.quotient, bus.remainder);
        end
`endif
        checks++;
        if (bus.quotient !== e.q || bus.remainder !== e.r ||
            bus.count !== 4'd15 || bus.state_out !== 4'd8) begin
            failures++;
            $display("FAIL done_state got=%h/%h/%0d/%0d required=%h/%h/15/8",
                     bus.quotient, bus.remainder, bus.count,
                     bus.state_out, e.q, e.r);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.state_out !== 4'd0 ||
            bus.quotient !== e.q) begin
            failures++;
            $display("FAIL done_pulse got=%0b/%0d/%h required=0/0/%h",
                     bus.done, bus.state_out, bus.quotient, e.q);
        end
    endtask

    task automatic test_unsigned;
        logic [15:0] ta[6] = '{16'd65535, 16'd5, 16'd12345, 16'd40000,
                               16'd255, 16'd0};
        logic [7:0]  tb[6] = '{8'd255, 8'd9, 8'd1, 8'd200, 8'd16, 8'd3};
        exp_t e;
        int   n;
        logic [15:0] a;
        logic [7:0]  b;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                a = ta[i];
                b = tb[i];
            end else begin
                a = 16'($urandom);
                do b = 8'($urandom); while (b == 8'd0);
            end
            start_op(a, b, 1'b1);
            wait_done(n);
            pop_exp(e);
            checks++;
            if (n !== 16 || bus.quotient !== e.q ||
                bus.remainder !== e.r) begin
                failures++;
                $display("FAIL div_%0d_%0d got=%h/%h n=%0d required=%h/%h n=16",
                         a, b, bus.quotient, bus.remainder, n, e.q, e.r);
            end
            tick();
        end
    endtask

    task automatic test_div_zero;
        exp_t e;
        int   n;
        int   seen;
        start_op(16'h1234, 8'd0, 1'b0);
        checks++;
        if (bus.state_out !== 4'd9 || bus.div_by_zero !== 1'b1 ||
            bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL dbz_state got=%0d/%0b/%0b required=9/1/0",
                     bus.state_out, bus.div_by_zero, bus.busy);
        end
        checks++;
        if (bus.quotient !== 16'hFFFF || bus.remainder !== 8'h34) begin
            failures++;
            $display("FAIL dbz_res got=%h/%h required=ffff/34",
                     bus.quotient, bus.remainder);
        end
        seen = 0;
        repeat (20) begin
            tick();
            if (bus.done === 1'b1 || bus.state_out !== 4'd9) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL dbz_hold got=%0d required=0", seen);
        end
        bus.dividend = 16'd300;
        bus.divisor  = 8'd7;
        bus.start    = 1'b1;
        tick();
        checks++;
        if (bus.state_out !== 4'd1 || bus.div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL err_exit got=%0d/%0b required=1/0",
                     bus.state_out, bus.div_by_zero);
        end
        bus.start = 1'b0;
        tick();
        sbq.push_back(model(16'd300, 8'd7));
        wait_done(n);
        pop_exp(e);
        checks++;
        if (n !== 16 || bus.quotient !== e.q || bus.remainder !== e.r) begin
            failures++;
            $display("FAIL after_dbz got=%h/%h required=%h/%h",
                     bus.quotient, bus.remainder, e.q, e.r);
        end
        tick();
    endtask

    task automatic test_abort;
        exp_t e;
        int   n;
        int   seen;
        bus.dividend = 16'd100;
        bus.divisor  = 8'd3;
        bus.start    = 1'b1;
        tick();
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.state_out !== 4'd9 || bus.div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL abort_load got=%0d/%0b required=9/0",
                     bus.state_out, bus.div_by_zero);
        end
        start_op(16'd5000, 8'd13, 1'b0);
        repeat (3) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.state_out !== 4'd9) begin
            failures++;
            $display("FAIL abort_calc got=%0d required=9", bus.state_out);
        end
        seen = 0;
        repeat (20) begin
            tick();
            if (bus.done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_done got=%0d required=0", seen);
        end
        start_op(16'd777, 8'd5, 1'b1);
        wait_done(n);
        pop_exp(e);
        checks++;
        if (n !== 16 || bus.quotient !== e.q || bus.remainder !== e.r) begin
            failures++;
            $display("FAIL after_abort got=%h/%h required=%h/%h",
                     bus.quotient, bus.remainder, e.q, e.r);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        start_op(16'd50000, 8'd3, 1'b0);
        repeat (4) tick();
        reset_a = 1'b1;
        tick();
        checks++;
        if ({bus.state_out, bus.count, bus.done, bus.busy} !== 10'd0 ||
            {bus.quotient, bus.remainder} !== 24'd0) begin
            failures++;
            $display("FAIL rst_mid got=%0d/%0d/%0b/%0b/%h/%h required=0",
                     bus.state_out, bus.count, bus.done, bus.busy,
                     bus.quotient, bus.remainder);
        end
        reset_a = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        exp_t        e;
        int          n;
        logic [15:0] a;
        logic [7:0]  b;
        start_op(16'd65000, 8'd77, 1'b1);
        wait_done(n);
        for (int i = 0; i < 5; i++) begin
            pop_exp(e);
            checks++;
            if (bus.quotient !== e.q || bus.remainder !== e.r) begin
                failures++;
                $display("FAIL b2b_res%0d got=%h/%h required=%h/%h",
                         i, bus.quotient, bus.remainder, e.q, e.r);
            end
            if (i < 4) begin
                a = 16'($urandom);
                do b = 8'($urandom); while (b == 8'd0);
                bus.dividend = a;
                bus.divisor  = b;
                bus.start    = 1'b1;
                tick();
                checks++;
                if (bus.state_out !== 4'd1) begin
                    failures++;
                    $display("FAIL b2b_load%0d got=%0d required=1",
                             i, bus.state_out);
                end
                bus.start = 1'b0;
                tick();
                sbq.push_back(model(a, b));
                wait_done(n);
                checks++;
                if (n + 2 !== 18) begin
                    failures++;
                    $display("FAIL b2b_period%0d got=%0d required=18",
                             i, n + 2);
                end
            end
        end
        tick();
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed;
        exp_t e;
        int   n;
        start_op(16'hFC18, 8'd7, 1'b1);
        wait_done(n);
        pop_exp(e);
        checks++;
        if (bus.quotient !== 16'hFF72 || bus.remainder !== 8'hFA ||
            e.q !== 16'hFF72) begin
            failures++;
            $display("FAIL s_m1000_7 got=%h/%h required=ff72/fa",
                     bus.quotient, bus.remainder);
        end
        tick();
        start_op(16'h8000, 8'hFF, 1'b1);
        wait_done(n);
        pop_exp(e);
        checks++;
        if (bus.quotient !== 16'h8000 || bus.remainder !== 8'h00) begin
            failures++;
            $display("FAIL s_minneg got=%h/%h required=8000/00",
                     bus.quotient, bus.remainder);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_unsigned();
        test_div_zero();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
